key_switch_io: RTL and testbench
================================

# key_switch_io

Memory-mapped input controller that lets the processor read the board's KEY pushbuttons and SW slide switches. It sits on the processor's data-memory bus next to data RAM and the HEX/LEDR output devices. It synchronizes and edge-detects KEY, debounces SW, and keeps per-device Ready/Overrun status. It raises an interrupt request when enabled status is pending.

## Interface
- DBITS, 32: bus address/data width.
- KDATA_ADDR, 32'hF0000010: key data register (read-only).
- KCTRL_ADDR, 32'hF0000110: key control/status register.
- SDATA_ADDR, 32'hF0000014: switch data register (read-only).
- SCTRL_ADDR, 32'hF0000114: switch control/status register.
- DEBOUNCE_CYCLES, 500000: cycles SW must be stable before it is accepted (10 ms at 50 MHz); minimum 2.

- CLOCK_50, in, 1: sole clock; all state updates on its rising edge.
- RESET_N, in, 1: synchronous, active-low reset.
- KEY, in, 4: pushbuttons, active-low (0 = pressed), asynchronous.
- SW, in, 10: slide switches, asynchronous.
- addr, in, DBITS: bus address.
- rd_en, in, 1: bus read strobe.
- wr_en, in, 1: bus write strobe.
- wdata, in, DBITS: bus write data.
- rdata, out, DBITS: read data, combinational from addr/rd_en.
- sel, out, 1: addr matches one of the four registers.
- intr, out, 1: (KRdy & KIE) | (SRdy & SIE), registered state only.

## Operation
- Register layouts:
  - KDATA: bits[3:0] = pressed keys (1 = pressed).
  - SDATA: bits[9:0] = switch state.
  - KCTRL/SCTRL: bit0 Rdy, bit1 Ovr, bit4 IE; all other bits read 0.
- Key path: two-flop synchronizer on ~KEY (ks1, ks2). When ks2 != kdata: kdata <= ks2 and a key change event is raised.
- Switch path: two-flop synchronizer (ss1, ss2), candidate register cand, counter cnt.
  - ss2 != cand: cand <= ss2, cnt <= 0.
  - Else, cand != sdata and cnt == DEBOUNCE_CYCLES-1: sdata <= cand, switch change event.
  - Else: cnt increments, saturating at DEBOUNCE_CYCLES-1.
- Status update, per device, evaluated every edge:
  - Change event: Rdy <= 1. If Rdy was already 1 and is not being cleared this cycle, Ovr <= 1.
  - Read of the DATA register (rd_en & addr==DATA): clears Rdy, unless a change event occurs the same edge, in which case Rdy stays 1 and Ovr is not set.
  - Write to CTRL:
    - IE <= wdata[4].
    - Rdy cleared if wdata[0]==0; Ovr cleared if wdata[1]==0. Writing 1 never sets either bit.
    - A same-edge change event takes precedence: sets Rdy (and Ovr if the rule above applies).
  - Writes to DATA addresses are ignored.
- Bus reads:
  - rdata = selected register, zero-extended to DBITS, when rd_en & sel; otherwise 0.
  - Reading CTRL has no side effects.

## Timing
- Reset (RESET_N low at a rising edge): ks1, ks2, kdata, ss1, ss2, cand, sdata, cnt, all Rdy/Ovr/IE <= 0.
  - Outputs after reset: rdata=0 (combinational), sel per addr, intr=0.
  - Reset mid-debounce discards the candidate; no event fires.
- KEY latency: a KEY change present before edge t appears in KDATA, with KRdy=1, after edge t+2 (3 edges).
- SW latency: a SW change held stable from before edge t updates SDATA, with SRdy=1, after edge t+DEBOUNCE_CYCLES+2.
  - Any SW change before acceptance restarts the count.
  - A change back to the current sdata value before acceptance produces no event.
- After reset, KEY held at 0 (all pressed) yields KDATA=4'hF and KRdy=1 three edges after release of RESET_N. This is expected.
- Status side effects of a read/write appear the edge after the strobe cycle. intr follows registered state, so it has one edge of latency from the event.

## Test plan
- Reset, KEY=4'hF, SW=0, DEBOUNCE_CYCLES=4 -> reads of all four registers return 0, intr=0.
- KEY 4'hF->4'hE -> after 3 edges KDATA=1, KCTRL=0x1. Read KDATA -> next cycle KCTRL=0x0.
- Two KEY changes with no read -> KCTRL=0x3. Write KCTRL=0x10 -> KCTRL=0x10, intr=0. Next KEY change -> KCTRL=0x11, intr=1 one edge later.
- SW=0x3FF held 3 cycles then back to 0 -> SDATA stays 0, SCTRL=0. SW=0x3FF held -> SDATA=0x3FF and SCTRL=0x1 exactly 7 edges after the change.
- Read KDATA on the same edge a new key event lands -> KCTRL=0x1 (Rdy kept, Ovr 0). Write KCTRL=0x00 on an event edge -> KCTRL=0x1.
- Assert RESET_N=0 with SW debounce at cnt=2 -> SDATA=0, SCTRL=0. After release, SDATA updates only after the full 7-edge latency.

Source files
------------

// File: rtl/key_switch_io.sv
// Memory-mapped KEY/SW input device: synchronizes and edge-detects KEY, debounces SW,
// and keeps per-device Rdy/Ovr/IE status with an interrupt request.
module key_switch_io #(
  parameter int                 DBITS           = 32,
  parameter logic [DBITS-1:0]   KDATA_ADDR      = 32'hF0000010,
  parameter logic [DBITS-1:0]   KCTRL_ADDR      = 32'hF0000110,
  parameter logic [DBITS-1:0]   SDATA_ADDR      = 32'hF0000014,
  parameter logic [DBITS-1:0]   SCTRL_ADDR      = 32'hF0000114,
  parameter int                 DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             intr
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    ks1, ks2, kdata;
  logic [9:0]    ss1, ss2, cand, sdata;
  logic [CW-1:0] cnt;
  logic          krdy, kovr, kie;
  logic          srdy, sovr, sie;

  logic          k_evt, s_evt, s_accept;
  logic          k_rd, s_rd, k_wr, s_wr;
  logic [2:0]    k_stat_nxt, s_stat_nxt;
  logic          unused_wdata;

  assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3:2]};

  // KEY is active-low; store pressed keys as 1
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      ks1   <= '0;
      ks2   <= '0;
      kdata <= '0;
    end else begin
      ks1 <= ~KEY;
      ks2 <= ks1;
      if (k_evt) kdata <= ks2;
    end
  end

  assign k_evt    = (ks2 != kdata);
  assign s_accept = (ss2 == cand) && (cand != sdata) && (cnt == CNT_MAX);
  assign s_evt    = s_accept;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      ss1   <= '0;
      ss2   <= '0;
      cand  <= '0;
      sdata <= '0;
      cnt   <= '0;
    end else begin
      ss1 <= SW;
      ss2 <= ss1;
      if (ss2 != cand) begin
        cand <= ss2;
        cnt  <= '0;
      end else if (s_accept) begin
        sdata <= cand;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign k_rd = rd_en && (addr == KDATA_ADDR);
  assign s_rd = rd_en && (addr == SDATA_ADDR);
  assign k_wr = wr_en && (addr == KCTRL_ADDR);
  assign s_wr = wr_en && (addr == SCTRL_ADDR);

  // Returns {ie, ovr, rdy}; a change event wins over any same-edge clear
  function automatic logic [2:0] status_next(
    input logic       rdy,
    input logic       ovr,
    input logic       ie,
    input logic       evt,
    input logic       rd,
    input logic       wr,
    input logic [1:0] wd_clr,
    input logic       wd_ie
  );
    logic rdy_clr;
    logic n_rdy, n_ovr, n_ie;
    rdy_clr = rd || (wr && !wd_clr[0]);
    n_ie    = wr ? wd_ie : ie;
    n_rdy   = rdy;
    n_ovr   = ovr;
    if (wr && !wd_clr[1]) n_ovr = 1'b0;
    if (evt) begin
      n_rdy = 1'b1;
      if (rdy && !rdy_clr) n_ovr = 1'b1;
    end else if (rdy_clr) begin
      n_rdy = 1'b0;
    end
    return {n_ie, n_ovr, n_rdy};
  endfunction

  always_comb begin
    k_stat_nxt = status_next(krdy, kovr, kie, k_evt, k_rd, k_wr, wdata[1:0], wdata[4]);
    s_stat_nxt = status_next(srdy, sovr, sie, s_evt, s_rd, s_wr, wdata[1:0], wdata[4]);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      {kie, kovr, krdy} <= 3'b000;
      {sie, sovr, srdy} <= 3'b000;
    end else begin
      {kie, kovr, krdy} <= k_stat_nxt;
      {sie, sovr, srdy} <= s_stat_nxt;
    end
  end

  assign intr = (krdy && kie) || (srdy && sie);

  always_comb begin
    sel   = 1'b0;
    rdata = '0;
    case (addr)
      KDATA_ADDR: begin
        sel = 1'b1;
        if (rd_en) rdata = DBITS'(kdata);
      end
      KCTRL_ADDR: begin
        sel = 1'b1;
        if (rd_en) rdata = DBITS'({kie, 2'b00, kovr, krdy});
      end
      SDATA_ADDR: begin
        sel = 1'b1;
        if (rd_en) rdata = DBITS'(sdata);
      end
      SCTRL_ADDR: begin
        sel = 1'b1;
        if (rd_en) rdata = DBITS'({sie, 2'b00, sovr, srdy});
      end
      default: begin
        sel   = 1'b0;
        rdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_switch_io.sv
// Directed bench for key_switch_io with a short debounce window (4 cycles).
module tb_key_switch_io;

  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] KCTRL = 32'hF0000110;
  localparam logic [31:0] SDATA = 32'hF0000014;
  localparam logic [31:0] SCTRL = 32'hF0000114;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel, intr;

  int n_checks = 0;
  int n_fail   = 0;

  key_switch_io #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .SW(sw),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata),
    .rdata(rdata), .sel(sel), .intr(intr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // side-effect-free read: strobe is dropped well before the next edge
  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    rd_en = 1'b1;
    #1;
    check(tag, rdata, exp);
    rd_en = 1'b0;
    #1;
  endtask

  task automatic rd_strobe(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr_strobe(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; key = 4'hF; sw = '0;
    addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // reset state
    peek(KDATA, 32'h0, "rst_kdata");
    peek(KCTRL, 32'h0, "rst_kctrl");
    peek(SDATA, 32'h0, "rst_sdata");
    peek(SCTRL, 32'h0, "rst_sctrl");
    check("rst_intr", {31'b0, intr}, 32'h0);
    addr = SCTRL; #1;
    check("sel_hit", {31'b0, sel}, 32'h1);
    addr = 32'hF0000018; #1;
    check("sel_miss", {31'b0, sel}, 32'h0);
    addr = KCTRL; rd_en = 1'b0; #1;
    check("rdata_no_rd", rdata, 32'h0);

    // key press latency and read-clear
    key = 4'hE;
    tick(2);
    peek(KDATA, 32'h0, "key_lat_early");
    tick();
    peek(KDATA, 32'h1, "key_lat_data");
    peek(KCTRL, 32'h1, "key_lat_rdy");
    rd_strobe(KDATA);
    peek(KCTRL, 32'h0, "key_rd_clr");
    peek(KDATA, 32'h1, "key_data_hold");

    // overrun, IE write, interrupt
    key = 4'hC; tick(3);
    key = 4'h8; tick(3);
    peek(KDATA, 32'h7, "key_two_data");
    peek(KCTRL, 32'h3, "key_ovr");
    wr_strobe(KCTRL, 32'h10);
    peek(KCTRL, 32'h10, "key_ie_wr");
    check("intr_ie_only", {31'b0, intr}, 32'h0);
    key = 4'h0; tick(2);
    check("intr_pre_evt", {31'b0, intr}, 32'h0);
    tick();
    peek(KCTRL, 32'h11, "key_ie_rdy");
    check("intr_key", {31'b0, intr}, 32'h1);
    wr_strobe(KCTRL, 32'h0);
    peek(KCTRL, 32'h0, "key_ctrl_clr");
    check("intr_cleared", {31'b0, intr}, 32'h0);
    wr_strobe(KDATA, 32'hFFFF_FFFF);
    peek(KDATA, 32'hF, "kdata_wr_ignored");

    // switch glitch shorter than debounce window, then a real change
    sw = 10'h3FF; tick(3);
    sw = 10'h000; tick(12);
    peek(SDATA, 32'h0, "sw_glitch_data");
    peek(SCTRL, 32'h0, "sw_glitch_ctrl");
    sw = 10'h3FF; tick(6);
    peek(SDATA, 32'h0, "sw_lat_early");
    tick();
    peek(SDATA, 32'h3FF, "sw_lat_data");
    peek(SCTRL, 32'h1, "sw_lat_rdy");
    rd_strobe(SDATA);
    peek(SCTRL, 32'h0, "sw_rd_clr");
    wr_strobe(SCTRL, 32'h10);
    sw = 10'h155; tick(7);
    peek(SDATA, 32'h155, "sw_ie_data");
    peek(SCTRL, 32'h11, "sw_ie_rdy");
    check("intr_sw", {31'b0, intr}, 32'h1);
    wr_strobe(SCTRL, 32'h0);
    peek(SCTRL, 32'h0, "sw_ctrl_clr");

    // read on the same edge as a key event keeps Rdy, no Ovr
    key = 4'hE; tick(3);
    peek(KCTRL, 32'h1, "key_pre_rdy");
    key = 4'hF; tick(2);
    rd_strobe(KDATA);
    peek(KDATA, 32'h0, "rd_evt_data");
    peek(KCTRL, 32'h1, "rd_evt_ctrl");
    // CTRL write clearing all bits on an event edge
    key = 4'hE; tick(2);
    wr_strobe(KCTRL, 32'h0);
    peek(KCTRL, 32'h1, "wr_evt_ctrl");

    // reset in the middle of a debounce window
    sw = 10'h2AA; tick(5);
    rst_n = 1'b0; tick();
    peek(SDATA, 32'h0, "mid_rst_sdata");
    peek(SCTRL, 32'h0, "mid_rst_sctrl");
    peek(KCTRL, 32'h0, "mid_rst_kctrl");
    rst_n = 1'b1;
    tick(6);
    peek(SDATA, 32'h0, "post_rst_early");
    tick();
    peek(SDATA, 32'h2AA, "post_rst_data");
    peek(SCTRL, 32'h1, "post_rst_rdy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
